block_mem_responder: RTL and testbench

- Backing-store side of the cache block-transfer interface: serves whole 256-bit (8 x 32-bit word) block reads and writes requested by the cache refill/write-back logic.
- Holds a word-organised RAM.
- Models main-memory latency with a programmable wait, then moves one word per cycle between RAM and a block buffer.
- Reports busy/idle on memready.

---
 rtl/block_mem_responder.sv | 97 +++++++++
 tb/tb_block_mem_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/block_mem_responder.sv
// Block-transfer backing store: waits LATENCY cycles, then moves one 32-bit word per cycle for a 256-bit block.
// Optional BLOCKMEM_ERR_EN: out-of-range block addresses skip the RAM access and pulse err instead of wrapping.
module block_mem_responder #(
  parameter int NBLOCKS = 256,
  parameter int LATENCY = 4,
  parameter int WORDS   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blockwrite,
  input  logic         blockread,
  input  logic [31:0]  blockaddr,
  input  logic [255:0] writeblock,
  output logic [255:0] readblock,
  output logic         memready,
  output logic         err
);
  localparam int AW = $clog2(NBLOCKS);
  localparam int IW = $clog2(WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS-1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  state_t                 state;
  logic                   is_wr;
  logic                   bad;
  logic [AW-1:0]          addr;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  // Packed element WORDS-1 sits in the top bits, so word i lives at [LAST-i].
  logic [WORDS-1:0][31:0] wbuf;
  logic [WORDS-1:0][31:0] rbuf;
  logic [31:0]            ram [NBLOCKS*WORDS];
  logic                   oor;

`ifdef BLOCKMEM_ERR_EN
  assign oor = (blockaddr >= 32'(NBLOCKS));
`else
  logic unused_hi;
  assign oor       = 1'b0;
  assign unused_hi = ^blockaddr[31:AW];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      memready  <= 1'b1;
      readblock <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      is_wr     <= 1'b0;
      bad       <= 1'b0;
      addr      <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (blockread | blockwrite) begin
          is_wr    <= blockwrite;
          bad      <= oor;
          addr     <= blockaddr[AW-1:0];
          wbuf     <= writeblock;
          cnt      <= CW'(LATENCY-1);
          memready <= 1'b0;
          state    <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          idx   <= '0;
          state <= XFER;
        end else begin
          cnt <= cnt - 1'b1;
        end
        XFER: begin
          if (!is_wr) rbuf[LAST-idx] <= bad ? 32'h0 : ram[{addr, idx}];
          if (idx == LAST) state <= DONE;
          else             idx   <= idx + 1'b1;
        end
        DONE: begin
          memready <= 1'b1;
          err      <= bad;
          if (!is_wr) readblock <= rbuf;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM has no reset: an aborted write keeps whatever words it already committed.
  always_ff @(posedge clk) begin
    if (state == XFER && is_wr && !bad) ram[{addr, idx}] <= wbuf[LAST-idx];
  end

endmodule

// File: tb/tb_block_mem_responder.sv
// Randomized bench for block_mem_responder against a block-level memory model.
module tb_block_mem_responder;
  localparam int NBLOCKS = 256;
  localparam int LATENCY = 4;
  localparam int ABORT   = 6;
`ifdef BLOCKMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         blockwrite, blockread;
  logic [31:0]  blockaddr;
  logic [255:0] writeblock, readblock;
  logic         memready, err;

  block_mem_responder #(.NBLOCKS(NBLOCKS), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .blockwrite(blockwrite), .blockread(blockread),
    .blockaddr(blockaddr), .writeblock(writeblock), .readblock(readblock),
    .memready(memready), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [255:0] mem [NBLOCKS];
  bit           vld [NBLOCKS];
  logic [255:0] exp_rb = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd_blk();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[255-32*i -: 32] = $urandom();
    return d;
  endfunction

  // One full transfer; when pulse is set a stray read of block 7 is held across the next edge.
  task automatic run(input bit wr, input bit rd, input logic [31:0] a, input logic [255:0] d,
                     input bit pulse, input string tag);
    int n;
    bit oor;
    blockwrite = wr; blockread = rd; blockaddr = a; writeblock = d;
    @(posedge clk); #1;
    if (pulse) begin
      blockread = 1'b1; blockwrite = 1'b0; blockaddr = 32'd7; writeblock = rnd_blk();
    end else begin
      blockread = 1'b0; blockwrite = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!memready && n < 100) begin
      n++;
      if (n == 2) begin blockread = 1'b0; blockwrite = 1'b0; end
      @(negedge clk);
    end
    blockread = 1'b0; blockwrite = 1'b0;
    oor = ERR_EN && (a >= NBLOCKS);
    if (wr) begin
      if (!oor) begin mem[a % NBLOCKS] = d; vld[a % NBLOCKS] = 1'b1; end
    end else begin
      exp_rb = oor ? '0 : mem[a % NBLOCKS];
    end
    chk({tag, "_lat"}, 256'(n), 256'(LATENCY + 9));
    chk({tag, "_rb"}, readblock, exp_rb);
    chk({tag, "_err"}, 256'(err), 256'(oor));
    @(negedge clk);
    chk({tag, "_err_off"}, 256'(err), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [255:0] d, dold, dnew, w;
    int b;
    for (int i = 0; i < NBLOCKS; i++) vld[i] = 1'b0;
    reset = 1'b1; blockwrite = 1'b0; blockread = 1'b0; blockaddr = '0; writeblock = '0;
    #12;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 256'(memready), 256'(1));
    chk("rst_rb", readblock, '0);
    chk("rst_err", 256'(err), 256'(0));

    for (int i = 0; i < 8; i++) d[255-32*i -: 32] = i;
    run(1'b1, 1'b0, 32'd3, d, 1'b0, "w3");
    run(1'b0, 1'b1, 32'd3, rnd_blk(), 1'b0, "r3");
    chk("r3_literal", readblock, 256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007);

    run(1'b1, 1'b1, 32'd5, {8{32'hA5A5A5A5}}, 1'b0, "both5");
    run(1'b0, 1'b1, 32'd5, '0, 1'b0, "r5");

    run(1'b1, 1'b0, 32'd2, rnd_blk(), 1'b0, "w2");
    run(1'b1, 1'b0, 32'd7, rnd_blk(), 1'b0, "w7");
    run(1'b0, 1'b1, 32'd2, '0, 1'b1, "pulse2");

    // abort a write mid-transfer; words committed before reset hold new data
    dold = rnd_blk(); dnew = rnd_blk();
    run(1'b1, 1'b0, 32'd9, dold, 1'b0, "w9old");
    blockwrite = 1'b1; blockaddr = 32'd9; writeblock = dnew;
    @(posedge clk); #1 blockwrite = 1'b0;
    repeat (ABORT) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_ready", 256'(memready), 256'(1));
    chk("abort_rb", readblock, '0);
    chk("abort_err", 256'(err), 256'(0));
    w = dold;
    for (int i = 0; i < 8; i++)
      if (i < ABORT - LATENCY) w[255-32*i -: 32] = dnew[255-32*i -: 32];
    mem[9] = w;
    exp_rb = '0;
    @(negedge clk); reset = 1'b0;
    run(1'b0, 1'b1, 32'd9, '0, 1'b0, "abort_r9");

    run(1'b1, 1'b0, 32'd1, rnd_blk(), 1'b0, "w1");
    run(1'b0, 1'b1, 32'(NBLOCKS + 1), '0, 1'b0, "oor_r");

    for (int it = 0; it < 24; it++) begin
      b = $urandom_range(0, 15);
      d = ERR_EN ? 32'(b) : 32'(b + NBLOCKS * $urandom_range(0, 3));
      if (!vld[b] || $urandom_range(0, 1) == 1)
        run(1'b1, 1'($urandom_range(0, 1)), d[31:0], rnd_blk(), 1'b0, "rnd_w");
      else
        run(1'b0, 1'b1, d[31:0], rnd_blk(), 1'b0, "rnd_r");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
